// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI slave front end.
package spi_pkg;

  localparam int unsigned SPI_WORD_W          = 8;
  localparam int unsigned SPI_BIT_CNT_W       = 3;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser; resets to the pin's idle level.
module sync_ff #(
  parameter int unsigned DEPTH   = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {DEPTH{RST_VAL}};
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 slave, fully oversampled in the clk domain: delivers received
// bytes with a one-cycle byte_sync strobe and shifts tx_data out on miso.
module spi_bridge
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  byte_sync,
  output logic [SPI_WORD_W-1:0] rx_data,
  input  logic [SPI_WORD_W-1:0] tx_data
);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_d, cs_n_d;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_state_e state, state_next;

  logic [SPI_WORD_W-1:0]    rx_shift;
  logic [SPI_WORD_W-1:0]    tx_shift;
  logic [SPI_BIT_CNT_W-1:0] bit_cnt;
  logic                     load_pending;
  logic                     miso_next;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
  );
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s)
  );
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      cs_n_d <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_n_d <= cs_n_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_n_s & cs_n_d;
  assign cs_rise   = cs_n_s & ~cs_n_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SPI_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (state == SPI_IDLE) begin
      if (cs_fall) state_next = SPI_ACTIVE;
    end else begin
      if (cs_rise) state_next = SPI_IDLE;
    end
  end

  always_comb begin
    miso_next = 1'b0;
    if (state == SPI_ACTIVE) miso_next = tx_shift[SPI_WORD_W-1];
  end

  // cs_n edges take priority over any sclk edge seen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso         <= 1'b0;
      byte_sync    <= 1'b0;
      rx_data      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      bit_cnt      <= '0;
      load_pending <= 1'b0;
    end else begin
      byte_sync <= 1'b0;
      miso      <= miso_next;
      if (state == SPI_IDLE) begin
        if (cs_fall) begin
          bit_cnt      <= '0;
          load_pending <= 1'b0;
          tx_shift     <= tx_data;
        end
      end else begin
        if (cs_rise) begin
          bit_cnt      <= '0;
          load_pending <= 1'b0;
        end else if (sclk_rise) begin
          rx_shift <= {rx_shift[SPI_WORD_W-2:0], mosi_s};
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == '1) begin
            rx_data      <= {rx_shift[SPI_WORD_W-2:0], mosi_s};
            byte_sync    <= 1'b1;
            load_pending <= 1'b1;
          end
        end else if (sclk_fall) begin
          if (load_pending) begin
            tx_shift     <= tx_data;
            load_pending <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[SPI_WORD_W-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
